// File: rtl/census_3x3_stream.sv
// Streaming 3x3 census transform: one 8-bit census word per interior pixel.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   pix_in / in_sof valid this cycle (no backpressure)
//   in_sof     marks pixel (0,0) of a frame, qualified by in_valid
//   pix_in     pixel intensity, raster order
//   out_valid  census / out_x / out_y valid this cycle
//   census     census word, MSB first: NW N NE W E SW S SE (bit = neighbour < centre)
//   out_x      centre column
//   out_y      centre row
//   out_eof    high with the last output of a frame
module census_3x3_stream #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [PIX_W-1:0]         pix_in,
    output logic                     out_valid,
    output logic [7:0]               census,
    output logic [$clog2(IMG_W)-1:0] out_x,
    output logic [$clog2(IMG_H)-1:0] out_y,
    output logic                     out_eof
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } state_t;

    // One window column: rows y-2 (top), y-1 (mid), y (bot).
    typedef struct packed {
        logic [PIX_W-1:0] top;
        logic [PIX_W-1:0] mid;
        logic [PIX_W-1:0] bot;
    } col_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    col_t            lcol_q, lcol_d;   // column x-2
    col_t            ccol_q, ccol_d;   // column x-1 (holds the centre)

    logic            out_valid_q, out_valid_d;
    logic [7:0]      census_q, census_d;
    logic [XW-1:0]   out_x_q, out_x_d;
    logic [YW-1:0]   out_y_q, out_y_d;
    logic            out_eof_q, out_eof_d;

    // Line buffers: lb1 holds row y-1, lb2 holds row y-2.
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];

    logic            accept_c;
    logic [XW-1:0]   ex_c;
    logic [YW-1:0]   ey_c;
    col_t            cur_c;
    logic [PIX_W-1:0] cen_c;
    logic [7:0]      word_c;
    logic            last_col_c;
    logic            last_row_c;

    // Accept qualification, effective coordinates and census of the centred window.
    always_comb begin
        accept_c   = in_valid && ((state_q == RUN) || in_sof);
        ex_c       = in_sof ? '0 : x_q;
        ey_c       = in_sof ? '0 : y_q;
        cur_c.top  = lb2[ex_c];
        cur_c.mid  = lb1[ex_c];
        cur_c.bot  = pix_in;
        cen_c      = ccol_q.mid;
        word_c     = {lcol_q.top < cen_c, ccol_q.top < cen_c, cur_c.top < cen_c,
                      lcol_q.mid < cen_c,                     cur_c.mid < cen_c,
                      lcol_q.bot < cen_c, ccol_q.bot < cen_c, cur_c.bot < cen_c};
        last_col_c = (ex_c == XW'(IMG_W - 1));
        last_row_c = (ey_c == YW'(IMG_H - 1));
    end

    // Next-state, counters, window shift and output staging.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        lcol_d      = lcol_q;
        ccol_d      = ccol_q;
        out_valid_d = 1'b0;
        census_d    = census_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_eof_d   = 1'b0;

        if (accept_c) begin
            // History to the left of column 0 belongs to the previous row.
            lcol_d = (ex_c == '0) ? '0 : ccol_q;
            ccol_d = cur_c;

            if (last_col_c) begin
                x_d = '0;
                if (last_row_c) begin
                    y_d     = '0;
                    state_d = WAIT_SOF;
                end else begin
                    y_d     = ey_c + YW'(1);
                    state_d = RUN;
                end
            end else begin
                x_d     = ex_c + XW'(1);
                y_d     = ey_c;
                state_d = RUN;
            end

            if ((ex_c >= XW'(2)) && (ey_c >= YW'(2))) begin
                out_valid_d = 1'b1;
                census_d    = word_c;
                out_x_d     = ex_c - XW'(1);
                out_y_d     = ey_c - YW'(1);
                out_eof_d   = last_col_c && last_row_c;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_SOF;
            x_q         <= '0;
            y_q         <= '0;
            lcol_q      <= '0;
            ccol_q      <= '0;
            out_valid_q <= 1'b0;
            census_q    <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            lcol_q      <= lcol_d;
            ccol_q      <= ccol_d;
            out_valid_q <= out_valid_d;
            census_q    <= census_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_eof_q   <= out_eof_d;
        end
    end

    // Line buffers shift down one row per accepted column; reads see pre-edge data.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lb2[ex_c] <= lb1[ex_c];
            lb1[ex_c] <= pix_in;
        end
    end

    assign out_valid = out_valid_q;
    assign census    = census_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_census_3x3_stream.sv
// Self-checking bench for census_3x3_stream with an image-level reference model.
module tb_census_3x3_stream;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] pix_in = 8'd0;
    logic       out_valid;
    logic [7:0] census;
    logic [2:0] out_x;
    logic [2:0] out_y;
    logic       out_eof;

    int errors = 0;
    int checks = 0;
    int img [H][W];
    int cap [H][W];
    int nout;
    int neof;

    census_3x3_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .pix_in   (pix_in),
        .out_valid(out_valid),
        .census   (census),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_eof  (out_eof)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Census of centre (cx,cy) straight from the frame image, raster neighbour order.
    function automatic int census_ref(input int cx, input int cy);
        int r = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (!(dx == 0 && dy == 0))
                    r = (r << 1) | ((img[cy+dy][cx+dx] < img[cy][cx]) ? 1 : 0);
        return r;
    endfunction

    task automatic drive(input bit v, input bit sof, input int p);
        @(negedge clk);
        in_valid = v;
        in_sof   = sof;
        pix_in   = 8'(p);
    endtask

    // One cycle after the drive: check the registered outputs.
    task automatic observe(input bit exp, input int cx, input int cy);
        @(posedge clk);
        #1;
        if (exp) begin
            check("out_valid", int'(out_valid), 1);
            check("census", int'(census), census_ref(cx, cy));
            check("out_x", int'(out_x), cx);
            check("out_y", int'(out_y), cy);
            check("out_eof", int'(out_eof), (cx == W-2 && cy == H-2) ? 1 : 0);
        end else begin
            check("out_valid_idle", int'(out_valid), 0);
        end
        if (out_valid === 1'b1) begin
            nout++;
            if (out_eof === 1'b1) neof++;
            if (int'(out_y) < H && int'(out_x) < W) cap[int'(out_y)][int'(out_x)] = int'(census);
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0);
        observe(1'b0, 0, 0);
    endtask

    // 0: flat 50, 1: field 100 with (3,3)=0, 2: random 0..3, 3: random 0..255
    task automatic gen_image(input int mode);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (mode)
                    0:       img[y][x] = 50;
                    1:       img[y][x] = (x == 3 && y == 3) ? 0 : 100;
                    2:       img[y][x] = int'($urandom_range(3));
                    default: img[y][x] = int'($urandom_range(255));
                endcase
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                cap[y][x] = -1;
        nout = 0;
        neof = 0;
    endtask

    // Sends the first n raster pixels of img; gap_pct sets idle insertion.
    task automatic send_frame(input int gap_pct, input int n);
        for (int i = 0; i < n; i++) begin
            int x = i % W;
            int y = i / W;
            for (int g = 0; g < 3; g++)
                if (int'($urandom_range(99)) < gap_pct) idle();
            drive(1'b1, i == 0, img[y][x]);
            observe(x >= 2 && y >= 2, x - 1, y - 1);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_nout"}, nout, (W-2)*(H-2));
        check({tag, "_neof"}, neof, 1);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_census", int'(census), 0);
        check("rst_x", int'(out_x), 0);
        check("rst_y", int'(out_y), 0);
        check("rst_eof", int'(out_eof), 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();

        // Beats without in_sof after reset are ignored
        for (int i = 0; i < 2*W + 5; i++) begin
            drive(1'b1, 1'b0, int'($urandom_range(255)));
            observe(1'b0, 0, 0);
        end

        // Flat frame
        gen_image(0);
        send_frame(0, W*H);
        check_counts("flat");
        idle();

        // Single dark pixel in a flat field
        gen_image(1);
        send_frame(0, W*H);
        check_counts("dot");
        check("dot_c33", cap[3][3], 8'h00);
        check("dot_c22", cap[2][2], 8'h01);
        check("dot_c44", cap[4][4], 8'h80);
        check("dot_c32", cap[2][3], 8'h02);
        check("dot_c23", cap[3][2], 8'h08);
        check("dot_c52", cap[2][5], 8'h00);

        // Same frame with random gaps
        gen_image(1);
        send_frame(40, W*H);
        check_counts("gap");
        check("gap_c22", cap[2][2], 8'h01);
        check("gap_c44", cap[4][4], 8'h80);

        // Stray non-sof beats between frames, then random frames
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, int'($urandom_range(255)));
            observe(1'b0, 0, 0);
        end
        for (int f = 0; f < 4; f++) begin
            gen_image(2 + (f % 2));
            send_frame(25, W*H);
            check_counts("rand");
        end

        // Restart: frame A aborted at (4,2), then back-to-back frames B and C
        gen_image(3);
        send_frame(0, 2*W + 4);
        check("abortA_neof", neof, 0);
        gen_image(2);
        send_frame(0, W*H);
        check_counts("frameB");
        gen_image(3);
        send_frame(0, W*H);
        check_counts("frameC");

        // Asynchronous reset mid-frame at pixel (5,3)
        gen_image(3);
        send_frame(0, 3*W + 5);
        check("pre_rst_valid", int'(out_valid), 1);
        drive(1'b1, 1'b0, img[3][5]);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_census", int'(census), 0);
        check("arst_x", int'(out_x), 0);
        check("arst_y", int'(out_y), 0);
        check("arst_eof", int'(out_eof), 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        idle();
        gen_image(3);
        send_frame(0, W*H);
        check_counts("post_rst");
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
